mmio_timer: RTL and testbench
=============================

Name: mmio_timer

Overview:
- Memory-mapped timer/compare peripheral. It is the responder on the core's MMIO store/load path, alongside the UART and I2C peripherals.
- The MMU decodes the window. The core issues word writes with a one-cycle wr_en strobe and reads the registered rd_data.
- Provides a prescaled 32-bit free-running counter, a compare match with optional auto-reload and one-shot, a sticky pending flag and a level interrupt.

Parameters:
- PRESCALE_RST, 0, reset value of PRESCALE register.
- COMPARE_RST, 32'hFFFFFFFF, reset value of COMPARE register.

Ports:
- clk  input  1  system clock; all state on posedge.
- rst  input  1  synchronous, active-high reset.
- addr  input  3  word index within peripheral window (MMU address bits [4:2]).
- wr_en  input  1  single-cycle write strobe; qualified upstream by the MMU select and write-back phase.
- wr_data  input  32  store data.
- rd_data  output  32  registered read data for addr.
- irq  output  1  level interrupt = STATUS.pending & CTRL.irq_en.
- tick  output  1  one-cycle pulse on every counter increment or reload.

Behaviour:
- Register map (addr):
  - 0 CTRL: bit0 en, bit1 irq_en, bit2 reload, bit3 oneshot; other bits read 0.
  - 1 STATUS: bit0 pending; write 1 to clear, write 0 no effect.
  - 2 PRESCALE: 32 bit.
  - 3 COUNT: 32 bit.
  - 4 COMPARE: 32 bit.
  - 5–7: read 0, writes ignored.
- Reset values: CTRL=0, STATUS=0, PRESCALE=PRESCALE_RST, COUNT=0, COMPARE=COMPARE_RST, internal prescaler pcnt=0, rd_data=0, irq=0, tick=0.
- rd_data: rd_data <= reg[addr] every cycle (1-cycle latency, no read strobe, no read side effects). A read the cycle after a write returns the new value.
- Prescaler (runs only while en=1):
  - If pcnt==PRESCALE: pcnt<=0 and tick_int=1; else pcnt<=pcnt+1.
  - Counter advances once per PRESCALE+1 clocks.
  - PRESCALE=0 advances every clock.
  - en=0 freezes pcnt and COUNT; they are not cleared.
- On tick_int:
  - Match when COUNT==COMPARE: pending<=1.
  - On match with reload=1: COUNT<=0. Otherwise COUNT<=COUNT+1 (wraps FFFFFFFF->0, no flag on wrap).
  - On match with oneshot=1: en<=0 the same cycle.
  - tick pulses 1 cycle (registered, aligned with the COUNT update).
- Auto-reload period = (PRESCALE+1)*(COMPARE+1) clocks.
- Write priority and side effects:
  - Writes to COUNT or PRESCALE also clear pcnt.
  - CPU write to COUNT wins over a same-cycle tick update.
  - CPU write to CTRL wins over the oneshot auto-clear.
  - pending set by a match wins over a same-cycle W1C.
- Writing COMPARE below the current COUNT: no match until COUNT wraps through 2^32.
- irq is combinational from registers (no extra latency past the register update). irq stays high until pending is cleared or irq_en=0.
- rst asserted mid-count: every register returns to its reset value on that edge and no tick is emitted.

Test Plan:
- Reset: hold rst 2 cycles -> rd_data of every addr reads 0, except COMPARE=FFFFFFFF; irq=0, tick=0.
- Prescaled count: PRESCALE=3, COMPARE=FFFFFFFF, CTRL=1, run 40 clocks -> COUNT=10, tick pulses every 4th clock, pending=0.
- Auto-reload + irq: PRESCALE=0, COMPARE=4, CTRL=0x7 -> COUNT sequence 0,1,2,3,4,0,...; pending and irq rise together on the first 4->0 transition (5 clocks after enable); W1C STATUS=1 drops irq next cycle; it re-asserts 5 clocks later.
- One-shot: COMPARE=2, CTRL=0x9 -> after the match en reads 0, COUNT frozen at 3, pending=1, no further ticks.
- Collisions:
  - Write COUNT=0x100 in a tick cycle -> COUNT reads 0x100.
  - W1C STATUS in a match cycle -> pending stays 1.
- Wrap and edges:
  - COUNT=FFFFFFFE, COMPARE=1, reload=0 -> FFFFFFFF, 0, 1 (match, pending=1), 2.
  - Writes to addr 5–7 -> all reads unchanged; addr 5 reads 0.

Source files
------------

// File: rtl/mmio_timer.sv
// Memory-mapped prescaled 32-bit timer with compare match, auto-reload, one-shot,
// sticky pending flag and level interrupt. Single-cycle word writes, registered reads.
module mmio_timer #(
  parameter logic [31:0] PRESCALE_RST = 32'd0,
  parameter logic [31:0] COMPARE_RST  = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  addr,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        irq,
  output logic        tick
);

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 3;

  localparam logic [AW-1:0] A_CTRL     = AW'(0);
  localparam logic [AW-1:0] A_STATUS   = AW'(1);
  localparam logic [AW-1:0] A_PRESCALE = AW'(2);
  localparam logic [AW-1:0] A_COUNT    = AW'(3);
  localparam logic [AW-1:0] A_COMPARE  = AW'(4);

  logic          en;
  logic          irq_en;
  logic          reload;
  logic          oneshot;
  logic          pending;
  logic [DW-1:0] prescale;
  logic [DW-1:0] count;
  logic [DW-1:0] compare;
  logic [DW-1:0] pcnt;

  logic          wr_ctrl;
  logic          wr_status;
  logic          wr_prescale;
  logic          wr_count;
  logic          wr_compare;
  logic          tick_int;
  logic          match;
  logic [DW-1:0] rd_mux;

  // Address decode of the single-cycle write strobe
  always_comb begin
    wr_ctrl     = wr_en && (addr == A_CTRL);
    wr_status   = wr_en && (addr == A_STATUS);
    wr_prescale = wr_en && (addr == A_PRESCALE);
    wr_count    = wr_en && (addr == A_COUNT);
    wr_compare  = wr_en && (addr == A_COMPARE);
  end

  assign tick_int = en && (pcnt == prescale);
  assign match    = tick_int && (count == compare);
  assign irq      = pending && irq_en;

  // Control bits; a CPU write overrides the one-shot auto-disable
  always_ff @(posedge clk) begin
    if (rst) begin
      en      <= 1'b0;
      irq_en  <= 1'b0;
      reload  <= 1'b0;
      oneshot <= 1'b0;
    end else if (wr_ctrl) begin
      en      <= wr_data[0];
      irq_en  <= wr_data[1];
      reload  <= wr_data[2];
      oneshot <= wr_data[3];
    end else if (match && oneshot) begin
      en      <= 1'b0;
    end
  end

  // Sticky pending; a match in the same cycle beats write-1-to-clear
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
    end else if (match) begin
      pending <= 1'b1;
    end else if (wr_status && wr_data[0]) begin
      pending <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prescale <= PRESCALE_RST;
      compare  <= COMPARE_RST;
    end else begin
      if (wr_prescale) prescale <= wr_data;
      if (wr_compare)  compare  <= wr_data;
    end
  end

  // Prescaler restarts whenever the counter or its divisor is rewritten
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt <= '0;
    end else if (wr_prescale || wr_count) begin
      pcnt <= '0;
    end else if (en) begin
      pcnt <= tick_int ? '0 : pcnt + DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (wr_count) begin
      count <= wr_data;
    end else if (tick_int) begin
      count <= (match && reload) ? '0 : count + DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick <= 1'b0;
    end else begin
      tick <= tick_int;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (addr)
      A_CTRL:     rd_mux = {28'd0, oneshot, reload, irq_en, en};
      A_STATUS:   rd_mux = {31'd0, pending};
      A_PRESCALE: rd_mux = prescale;
      A_COUNT:    rd_mux = count;
      A_COMPARE:  rd_mux = compare;
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= rd_mux;
    end
  end

endmodule

// File: tb/tb_mmio_timer.sv
// Directed bench for mmio_timer: a register-level reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_mmio_timer;

  logic        clk;
  logic        rst;
  logic [2:0]  addr;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        irq;
  logic        tick;

  int n_cmp = 0;
  int n_err = 0;

  mmio_timer dut (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .irq     (irq),
    .tick    (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  bit          mvalid = 1'b0;
  logic [3:0]  m_ctrl;
  logic        m_pending;
  logic [31:0] m_prescale, m_count, m_compare, m_pcnt, m_rd;
  logic        m_tick;

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0:    return {28'd0, m_ctrl};
      3'd1:    return {31'd0, m_pending};
      3'd2:    return m_prescale;
      3'd3:    return m_count;
      3'd4:    return m_compare;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    logic        step, hit;
    logic [31:0] rv;
    if (rst) begin
      mvalid     = 1'b1;
      m_ctrl     = 4'd0;
      m_pending  = 1'b0;
      m_prescale = 32'd0;
      m_count    = 32'd0;
      m_compare  = 32'hFFFF_FFFF;
      m_pcnt     = 32'd0;
      m_rd       = 32'd0;
      m_tick     = 1'b0;
    end else if (mvalid) begin
      rv   = model_read(addr);
      step = m_ctrl[0] && (m_pcnt == m_prescale);
      hit  = step && (m_count == m_compare);
      if (m_ctrl[0]) m_pcnt = step ? 32'd0 : m_pcnt + 32'd1;
      if (step) m_count = (hit && m_ctrl[2]) ? 32'd0 : m_count + 32'd1;
      if (hit && m_ctrl[3]) m_ctrl[0] = 1'b0;
      if (wr_en && addr == 3'd1 && wr_data[0]) m_pending = 1'b0;
      if (hit) m_pending = 1'b1;
      if (wr_en) begin
        case (addr)
          3'd0: m_ctrl = wr_data[3:0];
          3'd2: begin m_prescale = wr_data; m_pcnt = 32'd0; end
          3'd3: begin m_count = wr_data; m_pcnt = 32'd0; end
          3'd4: m_compare = wr_data;
          default: ;
        endcase
      end
      m_rd   = rv;
      m_tick = step;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (mvalid) begin
      chk("rd_data", rd_data, m_rd);
      chk("irq", {31'd0, irq}, {31'd0, m_pending && m_ctrl[1]});
      chk("tick", {31'd0, tick}, {31'd0, m_tick});
    end
  end

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    addr = a; wr_data = d; wr_en = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string nm);
    addr = a;
    @(posedge clk); #1;
    chk(nm, rd_data, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; addr = 3'd0; wr_en = 1'b0; wr_data = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("reset_irq", {31'd0, irq}, 32'd0);
    chk("reset_tick", {31'd0, tick}, 32'd0);
    for (int a = 0; a < 8; a++)
      rd(3'(a), (a == 4) ? 32'hFFFF_FFFF : 32'd0, "reset_read");

    // Prescaled count: divide by 4 for 40 clocks
    wr(3'd2, 32'd3);
    wr(3'd0, 32'd1);
    repeat (39) @(posedge clk);
    #1 wr(3'd0, 32'd0);
    rd(3'd3, 32'd10, "prescaled_count");
    rd(3'd1, 32'd0, "prescaled_pending");

    // Auto-reload with interrupt
    wr(3'd2, 32'd0);
    wr(3'd4, 32'd4);
    wr(3'd3, 32'd0);
    wr(3'd0, 32'd7);
    repeat (4) @(posedge clk);
    #1 chk("reload_irq_before", {31'd0, irq}, 32'd0);
    @(posedge clk); #1;
    chk("reload_irq_rise", {31'd0, irq}, 32'd1);
    wr(3'd1, 32'd1);
    chk("w1c_irq_drop", {31'd0, irq}, 32'd0);
    repeat (3) @(posedge clk);
    #1 chk("reload_irq_quiet", {31'd0, irq}, 32'd0);
    @(posedge clk); #1;
    chk("reload_irq_again", {31'd0, irq}, 32'd1);

    // W1C landing on a match cycle leaves pending set
    wr(3'd1, 32'd1);
    repeat (3) @(posedge clk);
    #1 wr(3'd1, 32'd1);
    chk("w1c_vs_match_irq", {31'd0, irq}, 32'd1);
    wr(3'd0, 32'd0);
    rd(3'd1, 32'd1, "w1c_vs_match_status");
    wr(3'd1, 32'd1);

    // CPU write to COUNT in a tick cycle wins
    wr(3'd4, 32'hFFFF_FFFF);
    wr(3'd0, 32'd1);
    wr(3'd3, 32'h100);
    rd(3'd3, 32'h100, "count_write_wins");
    wr(3'd0, 32'd0);

    // One-shot
    wr(3'd3, 32'd0);
    wr(3'd4, 32'd2);
    wr(3'd1, 32'd1);
    wr(3'd0, 32'd9);
    repeat (6) @(posedge clk);
    #1 rd(3'd0, 32'd8, "oneshot_ctrl");
    rd(3'd3, 32'd3, "oneshot_count");
    rd(3'd1, 32'd1, "oneshot_pending");
    chk("oneshot_tick", {31'd0, tick}, 32'd0);

    // Wrap through 2^32 then match at 1
    wr(3'd1, 32'd1);
    wr(3'd4, 32'd1);
    wr(3'd3, 32'hFFFF_FFFE);
    wr(3'd0, 32'd1);
    repeat (3) @(posedge clk);
    #1 wr(3'd0, 32'd0);
    rd(3'd3, 32'd2, "wrap_count");
    rd(3'd1, 32'd1, "wrap_pending");

    // Unmapped addresses
    wr(3'd5, 32'hDEAD_BEEF);
    wr(3'd6, 32'hDEAD_BEEF);
    wr(3'd7, 32'hDEAD_BEEF);
    rd(3'd5, 32'd0, "unmapped5");
    rd(3'd4, 32'd1, "unmapped_compare");
    rd(3'd3, 32'd2, "unmapped_count");
    rd(3'd2, 32'd0, "unmapped_prescale");

    // Reset in the middle of counting
    wr(3'd0, 32'd1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("midreset_tick", {31'd0, tick}, 32'd0);
    rst = 1'b0;
    rd(3'd3, 32'd0, "midreset_count");
    rd(3'd4, 32'hFFFF_FFFF, "midreset_compare");
    rd(3'd0, 32'd0, "midreset_ctrl");
    repeat (3) @(posedge clk);
    #1 chk("midreset_no_tick", {31'd0, tick}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
